// File: rtl/vip_pkg.sv
// Shared VIP definitions: capture states, output-select codes, threshold default
// and the frame-size helper used by the capture blocks.
package vip_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } cap_state_t;

    localparam logic [1:0] SEL_Y      = 2'd0;
    localparam logic [1:0] SEL_MEDIAN = 2'd1;
    localparam logic [1:0] SEL_SOBEL  = 2'd2;

    localparam logic [7:0] THRESH_DEFAULT = 8'd128;

    function automatic int unsigned frame_pixels(input int unsigned hdisp,
                                                 input int unsigned vdisp);
        return hdisp * vdisp;
    endfunction

endpackage

// File: rtl/vip_vsync_edge.sv
// Registers the frame-valid signal once and derives single-cycle frame start
// (rise) and frame end (fall) pulses from it.
module vip_vsync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic vs_rise,
    output logic vs_fall
);

    logic vs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vsync;
        end
    end

    assign vs_rise = vsync & ~vs_q;
    assign vs_fall = ~vsync & vs_q;

endmodule

// File: rtl/vip_frame_capture_ctrl.sv
// Frame-synchronous sequencer: applies runtime config only at frame end and runs an
// N-frame capture of the selected stream into a linear buffer with pixel-count checks.
module vip_frame_capture_ctrl
    import vip_pkg::*;
#(
    parameter int IMG_HDISP = 400,
    parameter int IMG_VDISP = 400,
    parameter int PIX_W     = 24,
    parameter int ADDR_W    = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_sel,
    input  logic [7:0]        cfg_thresh,
    output logic [1:0]        act_sel,
    output logic [7:0]        act_thresh,
    input  logic              cap_start,
    input  logic [7:0]        cap_frames,
    input  logic              in_vsync,
    input  logic              in_href,
    input  logic              in_clken,
    input  logic [PIX_W-1:0]  in_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              done,
    output logic              frame_err,
    output logic [7:0]        frames_done
);

    localparam int unsigned      FRAME_PIX = frame_pixels(IMG_HDISP, IMG_VDISP);
    localparam logic [ADDR_W:0]  FRAME_CNT = (ADDR_W+1)'(FRAME_PIX);

    cap_state_t        state;
    cap_state_t        state_nxt;
    logic              vs_rise;
    logic              vs_fall;
    logic              cfg_pend;
    logic [1:0]        pend_sel;
    logic [7:0]        pend_thresh;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic [7:0]        n_frames;
    logic [7:0]        frames_done_inc;
    logic              pix_ok;

    vip_vsync_edge u_vsync_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .vsync   (in_vsync),
        .vs_rise (vs_rise),
        .vs_fall (vs_fall)
    );

    assign pix_ok          = in_href & in_clken & in_vsync;
    assign frames_done_inc = frames_done + 8'd1;
    assign cfg_ready       = ~cfg_pend;
    assign busy            = (state == ST_ARM) | (state == ST_CAPTURE);
    assign done            = (state == ST_DONE);

    // A request accepted during a vs_fall cycle is not yet pending, so it waits a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_pend    <= 1'b0;
            pend_sel    <= SEL_Y;
            pend_thresh <= 8'd0;
            act_sel     <= SEL_Y;
            act_thresh  <= THRESH_DEFAULT;
        end else begin
            if (vs_fall && cfg_pend) begin
                act_sel    <= pend_sel;
                act_thresh <= pend_thresh;
                cfg_pend   <= 1'b0;
            end
            if (cfg_valid && cfg_ready) begin
                cfg_pend    <= 1'b1;
                pend_sel    <= (cfg_sel == 2'd3) ? SEL_Y : cfg_sel;
                pend_thresh <= cfg_thresh;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (cap_start) state_nxt = ST_ARM;
            ST_ARM:     if (vs_rise)   state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (vs_fall)   state_nxt = (frames_done_inc == n_frames) ? ST_DONE : ST_ARM;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Pixel counter saturates at one full frame; extra pixels only flag overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            overflow    <= 1'b0;
            n_frames    <= 8'd0;
            frames_done <= 8'd0;
            frame_err   <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cap_start) begin
                        n_frames    <= (cap_frames == 8'd0) ? 8'd1 : cap_frames;
                        frame_err   <= 1'b0;
                        frames_done <= 8'd0;
                    end
                end
                ST_ARM: begin
                    if (vs_rise) begin
                        count    <= '0;
                        overflow <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (pix_ok) begin
                        if (count < FRAME_CNT) begin
                            wr_en   <= 1'b1;
                            wr_addr <= count[ADDR_W-1:0];
                            wr_data <= in_data;
                            count   <= count + (ADDR_W+1)'(1);
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                    if (vs_fall) begin
                        frames_done <= frames_done_inc;
                        if ((count != FRAME_CNT) || overflow) begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vip_frame_capture_ctrl.sv
// Directed-plus-random bench for vip_frame_capture_ctrl on a 4x3 frame, checked
// against a frame-level model of config timing, capture arming and buffer writes.
module tb_vip_frame_capture_ctrl;

    localparam int HD     = 4;
    localparam int VD     = 3;
    localparam int FP     = HD * VD;
    localparam int PIX_W  = 24;
    localparam int ADDR_W = 4;

    typedef struct {
        int          addr;
        logic [23:0] data;
        longint      cyc;
    } wr_t;

    logic              clk;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_sel;
    logic [7:0]        cfg_thresh;
    logic [1:0]        act_sel;
    logic [7:0]        act_thresh;
    logic              cap_start;
    logic [7:0]        cap_frames;
    logic              in_vsync;
    logic              in_href;
    logic              in_clken;
    logic [PIX_W-1:0]  in_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic              busy;
    logic              done;
    logic              frame_err;
    logic [7:0]        frames_done;

    int     compCount = 0;
    int     errCount  = 0;
    longint cyc       = 0;
    int     doneCount = 0;
    wr_t    wrQ[$];
    wr_t    expQ[$];

    bit         mArmed;
    int         mLeft;
    int         mFd;
    bit         mErr;
    int         mDoneExp;
    logic [1:0] mActSel;
    logic [7:0] mActThr;
    bit         mPend;
    logic [1:0] mPendSel;
    logic [7:0] mPendThr;

    vip_frame_capture_ctrl #(
        .IMG_HDISP (HD),
        .IMG_VDISP (VD),
        .PIX_W     (PIX_W),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_sel     (cfg_sel),
        .cfg_thresh  (cfg_thresh),
        .act_sel     (act_sel),
        .act_thresh  (act_thresh),
        .cap_start   (cap_start),
        .cap_frames  (cap_frames),
        .in_vsync    (in_vsync),
        .in_href     (in_href),
        .in_clken    (in_clken),
        .in_data     (in_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .done        (done),
        .frame_err   (frame_err),
        .frames_done (frames_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        wr_t w;
        if (wr_en) begin
            w.addr = int'(wr_addr);
            w.data = wr_data;
            w.cyc  = cyc;
            wrQ.push_back(w);
        end
        if (done) doneCount++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compCount++;
        assert (obs === exp) else begin
            errCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mArmed   = 0;
        mLeft    = 0;
        mFd      = 0;
        mErr     = 0;
        mActSel  = 2'd0;
        mActThr  = 8'd128;
        mPend    = 0;
        mPendSel = 2'd0;
        mPendThr = 8'd0;
    endtask

    task automatic compareWrites(input string tag);
        int n;
        checkOutput({tag, "_wr_count"}, 32'(wrQ.size()), 32'(expQ.size()));
        n = (wrQ.size() < expQ.size()) ? wrQ.size() : expQ.size();
        for (int i = 0; i < n; i++) begin
            checkOutput({tag, "_wr_addr"}, 32'(wrQ[i].addr), 32'(expQ[i].addr));
            checkOutput({tag, "_wr_data"}, 32'(wrQ[i].data), 32'(expQ[i].data));
            checkOutput({tag, "_wr_cycle"}, 32'(wrQ[i].cyc), 32'(expQ[i].cyc));
        end
    endtask

    // One frame: vsync high, npix accepted pixels with random gaps, then vertical blank.
    task automatic applyStimulus(input string tag, input int npix, input int startAt,
                                 input int startN, input bit cfgReq, input logic [1:0] cSel,
                                 input logic [7:0] cThr, input int abortAt);
        bit         capThis;
        logic [1:0] oldSel;
        logic [7:0] oldThr;
        wr_t        e;
        capThis = mArmed;
        expQ.delete();
        wrQ.delete();
        in_vsync = 1'b1;
        step();
        step();
        for (int p = 0; p < npix; p++) begin
            repeat ($urandom_range(0, 2)) begin
                in_href  = 1'($urandom_range(0, 1));
                in_clken = 1'b0;
                step();
            end
            in_href    = 1'b1;
            in_clken   = 1'b1;
            in_data    = PIX_W'($urandom);
            cap_start  = (p == startAt);
            cap_frames = 8'(startN);
            cfg_valid  = cfgReq && (p == 1);
            cfg_sel    = cSel;
            cfg_thresh = cThr;
            if (capThis && p < FP) begin
                e.addr = p;
                e.data = in_data;
                e.cyc  = cyc + 1;
                expQ.push_back(e);
            end
            if (p == abortAt) begin
                rst_n = 1'b0;
                #1;
                checkOutput({tag, "_abort_busy"}, 32'(busy), 32'd0);
                checkOutput({tag, "_abort_wr_en"}, 32'(wr_en), 32'd0);
                in_href   = 1'b0;
                in_clken  = 1'b0;
                in_vsync  = 1'b0;
                cap_start = 1'b0;
                cfg_valid = 1'b0;
                step();
                step();
                rst_n = 1'b1;
                modelReset();
                step();
                expQ.delete();
                wrQ.delete();
                return;
            end
            step();
            in_clken  = 1'b0;
            in_href   = 1'b0;
            cap_start = 1'b0;
            cfg_valid = 1'b0;
            if (p == startAt && !mArmed) begin
                mArmed = 1;
                mLeft  = (startN == 0) ? 1 : startN;
                mFd    = 0;
                mErr   = 0;
                @(negedge clk);
                checkOutput({tag, "_start_busy"}, 32'(busy), 32'd1);
                checkOutput({tag, "_start_err_clr"}, 32'(frame_err), 32'd0);
                checkOutput({tag, "_start_fd_clr"}, 32'(frames_done), 32'd0);
            end
            if (cfgReq && p == 1 && !mPend) begin
                mPend    = 1;
                mPendSel = (cSel == 2'd3) ? 2'd0 : cSel;
                mPendThr = cThr;
                @(negedge clk);
                checkOutput({tag, "_cfg_ready_drop"}, 32'(cfg_ready), 32'd0);
                checkOutput({tag, "_act_sel_hold"}, 32'(act_sel), 32'(mActSel));
            end
        end
        step();
        oldSel   = mActSel;
        oldThr   = mActThr;
        in_vsync = 1'b0;
        if (mPend) begin
            mActSel = mPendSel;
            mActThr = mPendThr;
            mPend   = 0;
        end
        @(negedge clk);
        checkOutput({tag, "_act_sel_at_fall"}, 32'(act_sel), 32'(oldSel));
        checkOutput({tag, "_act_thr_at_fall"}, 32'(act_thresh), 32'(oldThr));
        step();
        @(negedge clk);
        checkOutput({tag, "_act_sel_after"}, 32'(act_sel), 32'(mActSel));
        checkOutput({tag, "_act_thr_after"}, 32'(act_thresh), 32'(mActThr));
        checkOutput({tag, "_cfg_ready"}, 32'(cfg_ready), 32'd1);
        if (capThis) begin
            mFd++;
            if (npix != FP) mErr = 1;
            mLeft--;
            if (mLeft == 0) begin
                mArmed = 0;
                mDoneExp++;
            end
        end
        repeat (3) step();
        @(negedge clk);
        compareWrites(tag);
        checkOutput({tag, "_frames_done"}, 32'(frames_done), 32'(mFd));
        checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'(mErr));
        checkOutput({tag, "_busy"}, 32'(busy), 32'(mArmed));
        checkOutput({tag, "_done_pulses"}, 32'(doneCount), 32'(mDoneExp));
    endtask

    initial begin
        int npix;
        int sa;
        rst_n      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_sel    = 2'd0;
        cfg_thresh = 8'd0;
        cap_start  = 1'b0;
        cap_frames = 8'd0;
        in_vsync   = 1'b0;
        in_href    = 1'b0;
        in_clken   = 1'b0;
        in_data    = '0;
        mDoneExp   = 0;
        modelReset();
        repeat (3) step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        checkOutput("rst_act_sel", 32'(act_sel), 32'd0);
        checkOutput("rst_act_thresh", 32'(act_thresh), 32'd128);
        checkOutput("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
        checkOutput("rst_frames_done", 32'(frames_done), 32'd0);

        applyStimulus("idle0", FP, -1, 0, 0, 2'd0, 8'd0, -1);
        applyStimulus("idle1", FP, -1, 0, 0, 2'd0, 8'd0, -1);

        applyStimulus("cfg", FP, -1, 0, 1, 2'd2, 8'd64, -1);

        applyStimulus("single_arm", FP, 5, 1, 0, 2'd0, 8'd0, -1);
        applyStimulus("single_cap", FP, -1, 0, 0, 2'd0, 8'd0, -1);

        applyStimulus("zero_arm", FP, 3, 0, 0, 2'd0, 8'd0, -1);
        applyStimulus("zero_cap", FP, -1, 0, 0, 2'd0, 8'd0, -1);

        applyStimulus("multi_arm", FP, 7, 3, 0, 2'd0, 8'd0, -1);
        applyStimulus("multi_f1", FP, -1, 0, 0, 2'd0, 8'd0, -1);
        applyStimulus("multi_f2", FP, 2, 7, 0, 2'd0, 8'd0, -1);
        applyStimulus("multi_f3", FP, -1, 0, 1, 2'd3, 8'd200, -1);

        applyStimulus("err_arm", FP, 4, 2, 0, 2'd0, 8'd0, -1);
        applyStimulus("err_short", FP - 1, -1, 0, 0, 2'd0, 8'd0, -1);
        applyStimulus("err_long", FP + 2, -1, 0, 0, 2'd0, 8'd0, -1);
        applyStimulus("err_rearm", FP, 6, 1, 0, 2'd0, 8'd0, -1);
        applyStimulus("err_clean", FP, -1, 0, 1, 2'd1, 8'd33, -1);

        applyStimulus("abort_arm", FP, 1, 2, 0, 2'd0, 8'd0, -1);
        applyStimulus("abort_cap", FP, -1, 0, 0, 2'd0, 8'd0, 6);
        applyStimulus("abort_after", FP, -1, 0, 0, 2'd0, 8'd0, -1);

        for (int k = 0; k < 10; k++) begin
            npix = int'($urandom_range(FP - 2, FP + 2));
            sa   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, FP - 3)) : -1;
            applyStimulus("rand", npix, sa, int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 2'($urandom), 8'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule

// File: doc/vip_frame_capture_ctrl.md
Name: vip_frame_capture_ctrl

Overview:
Frame-synchronous sequencer for the VIP pipeline output.
- Accepts runtime configuration (output select, Sobel threshold) via a valid/ready handshake. Applies it only at frame boundaries so no frame is processed with mixed settings.
- Arms and runs an N-frame capture of the selected post-processing stream into a linear pixel buffer.
- Checks each captured frame's pixel count and raises a sticky error on short or long frames.

Parameters:
IMG_HDISP, 400, active pixels per line
IMG_VDISP, 400, active lines per frame
PIX_W, 24, pixel data width (RGB888)
ADDR_W, 18, buffer address width; must satisfy 2^ADDR_W >= IMG_HDISP*IMG_VDISP

Ports:
clk  in  1  pixel clock
rst_n  in  1  reset, asynchronous, active-low
cfg_valid  in  1  config request valid
cfg_ready  out  1  high when no config is pending
cfg_sel  in  2  requested output select (0 = YCbCr Y, 1 = median, 2 = Sobel, 3 = reserved, treated as 0)
cfg_thresh  in  8  requested Sobel threshold
act_sel  out  2  active output select, drives the pipeline mux
act_thresh  out  8  active Sobel threshold
cap_start  in  1  single-cycle capture request
cap_frames  in  8  frames to capture, sampled with cap_start
in_vsync  in  1  frame valid; high = active frame, low = vertical sync
in_href  in  1  line valid
in_clken  in  1  pixel enable
in_data  in  PIX_W  pixel from selected stream
wr_en  out  1  buffer write strobe
wr_addr  out  ADDR_W  buffer write address
wr_data  out  PIX_W  buffer write data
busy  out  1  high in ARM or CAPTURE
done  out  1  one-cycle pulse when capture completes
frame_err  out  1  sticky pixel-count error
frames_done  out  8  frames completed in the current capture

Behaviour:
Reset values:
- act_sel = 0, act_thresh = 128
- cfg_ready = 1, busy = 0, done = 0, wr_en = 0, wr_addr = 0, wr_data = 0, frame_err = 0, frames_done = 0
- State = IDLE, all internal registers cleared
- Reset asserted mid-capture aborts immediately with no done pulse; the buffer contents are don't-care.

Edge detection:
- in_vsync is registered once.
- vs_rise = in_vsync & ~vs_q (frame start); vs_fall = ~in_vsync & vs_q (frame end).

Config path:
- A handshake (cfg_valid & cfg_ready) latches cfg_sel and cfg_thresh into pending registers and drops cfg_ready.
- On vs_fall with a config pending: act_* update on the following edge and cfg_ready returns to 1.
- A request accepted in the same cycle as vs_fall is applied at the next vs_fall, not the current one.
- Config may be applied in any state.

Capture state machine (IDLE, ARM, CAPTURE, DONE):
- IDLE: cap_start moves to ARM. cap_frames is latched, with 0 treated as 1. frame_err and frames_done are cleared.
- ARM: waits for vs_rise, then moves to CAPTURE and resets the pixel counter to 0. A vs_rise in the same cycle as cap_start is not used, so a partial frame is never captured.
- CAPTURE: each cycle with in_href & in_clken & in_vsync is an accepted pixel.
  - If count < IMG_HDISP*IMG_VDISP: write, then count += 1.
  - Otherwise: no write, count saturates, overflow flag set.
- CAPTURE, on vs_fall:
  - frames_done += 1.
  - If count != IMG_HDISP*IMG_VDISP or overflow: frame_err <= 1.
  - If frames_done + 1 == latched N: go to DONE. Otherwise go to ARM (the next vs_rise restarts at address 0; frames overwrite).
- DONE: done = 1 for one cycle, then IDLE.
- cap_start is ignored while busy.

Write port:
- Registered: wr_en, wr_addr (= count before increment) and wr_data (= in_data) appear 1 cycle after the accepted pixel.

Other rules:
- busy = (state == ARM) | (state == CAPTURE).
- frame_err stays set until the next accepted cap_start.
- Width: the pixel counter is ADDR_W+1 bits so the saturation compare never wraps.

Decomposition:
- Shared package vip_pkg:
  - state enum
  - SEL_Y / SEL_MEDIAN / SEL_SOBEL constants
  - THRESH_DEFAULT = 128
  - the FRAME_PIXELS = IMG_HDISP*IMG_VDISP function
- One sub-module, vip_vsync_edge: vsync register plus rise/fall pulses. Reused by other VIP blocks.
- The config handshake and the FSM stay inline.

Test Plan:
- Reset default: after reset release -> act_sel = 0, act_thresh = 128, cfg_ready = 1, busy = 0; no wr_en over 2 full frames.
- Config at boundary (IMG_HDISP = 4, IMG_VDISP = 3): cfg_sel = 2, cfg_thresh = 64 mid-frame -> cfg_ready drops next cycle; act_sel stays 0 until the cycle after vs_fall, then becomes 2/64; cfg_ready returns to 1.
- Single capture: cap_start with cap_frames = 1 mid-frame -> no writes in the current frame. Next frame: 12 wr_en pulses, addresses 0..11, each 1 cycle after its pixel. done pulses once after vs_fall; frames_done = 1; frame_err = 0.
- Multi-frame with cap_frames = 0: capture runs 1 frame. With cap_frames = 3: 36 writes, addresses wrap to 0 at each frame, done after the 3rd vs_fall.
- Short/long frame: a frame with 11 pixels -> frame_err = 1. A frame with 14 pixels -> only 12 writes, frame_err = 1, last wr_addr = 11. frame_err clears on the next cap_start.
- Abort and collisions: cap_start while busy -> ignored. rst_n low mid-CAPTURE -> wr_en and busy are 0 immediately; no done pulse.
